serial_byte_capture: RTL and testbench
======================================

Name: serial_byte_capture

Overview:
- Serial-to-parallel receiver for the pattern-memory streamer, which sends each byte LSB-first, one bit per clock.
- Reassembles 8-bit bytes from a 1-bit stream qualified by din_valid.
- Writes each completed byte into a 16x8 capture memory at an auto-incrementing address.
- Exposes an asynchronous read port so the bench or a downstream checker can inspect captured data.

Parameters:
- WIDTH, 8, bits per byte (serialisation order fixed LSB-first)
- DEPTH, 16, capture memory entries
- AW, 4, address width; must equal log2(DEPTH)
- WRAP, 0, 0 = stop writing at full and flag overflow; 1 = write address wraps and overwrites

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- clear  input  1  synchronous, active-high reset
- din  input  1  serial data bit
- din_valid  input  1  din is sampled on this edge when 1
- rd_addr  input  AW  capture-memory read address
- rd_data  output  WIDTH  mem[rd_addr], combinational read
- byte_out  output  WIDTH  last completed byte, registered
- byte_valid  output  1  one-cycle pulse: byte_out updated this cycle
- wr_addr  output  AW  next memory write address
- bit_cnt  output  3  bits received of the current byte (0..7)
- full  output  1  DEPTH bytes stored (WRAP=0 only)
- overflow  output  1  sticky; a byte completed while full

Behaviour:
- Interface is fixed: one clock; reset is synchronous and active-high. Clock port is clk, reset port is clear.
- Reset (clear=1 at a rising edge): shift reg=0, bit_cnt=0, wr_addr=0, byte_out=0, byte_valid=0, full=0, overflow=0.
  - Memory contents are not reset.
  - clear has priority over din_valid on the same edge.
- Bit sampling (din_valid=1, clear=0): shift[bit_cnt] <= din, then bit_cnt <= bit_cnt+1 mod 8. The first bit of a byte is bit 0.
- din_valid=0: all state holds. Gaps of any length between bits are legal and do not affect assembly.
- Byte completion (edge where bit_cnt==7 and din_valid=1):
  - Assembled byte = {din, shift[6:0]}.
  - Same edge: byte_out <= assembled byte; byte_valid <= 1, for exactly that following cycle; bit_cnt <= 0.
  - If full==0: mem[wr_addr] <= byte; wr_addr <= wr_addr+1 mod DEPTH.
  - If WRAP=0 and wr_addr==DEPTH-1: full <= 1 on the same edge; wr_addr wraps to 0 and then holds.
  - If full==1: no memory write, wr_addr holds, overflow <= 1 (sticky until clear).
  - byte_valid and byte_out still update when full.
- WRAP=1: full and overflow stay 0; the address wraps and old data is overwritten.
- byte_valid is 0 on every cycle that is not immediately after a completion edge.
- Latency: byte_out/byte_valid appear in the cycle after the edge sampling bit 7. rd_data reflects a new write from that same cycle.
- Read port: purely combinational. Reading the address being written returns the old value before the edge and the new value after it.
- clear mid-byte: the partial byte is discarded with no write. The next 8 valid bits form a fresh byte at address 0.
- Full-boundary case: clear on the same edge as a completion wins; nothing is written.

Decomposition:
- Shared package holds:
  - WIDTH, DEPTH, AW constants
  - pattern constants PAT_A=8'hCC and PAT_B=8'hAA, shared with the streaming transmitter side for loopback checking
- One sub-module: bit_assembler (shift reg + 3-bit bit counter + completion pulse).
- Top holds the memory, write-address counter, full/overflow flags and output registers.

Test Plan:
- Single byte: after clear, drive din=0,0,1,1,0,0,1,1 with din_valid=1 on 8 consecutive edges -> byte_valid=1 for one cycle, byte_out=8'hCC, wr_addr=1; with rd_addr=0, rd_data=8'hCC.
- Gapped bits: send 8'hAA LSB-first (0,1,0,1,0,1,0,1) with din_valid=0 for 3 cycles between each bit -> bit_cnt steps 1..7 then 0; byte_out=8'hAA; no byte_valid before the 8th bit.
- Fill, WRAP=0: stream 16 bytes alternating CC, AA -> full=1 after the 16th; even addresses read CC, odd read AA; overflow=0.
- Overflow, WRAP=0: send a 17th byte 8'h55 -> byte_out=8'h55 with byte_valid pulse, overflow=1, mem[0] still 8'hCC, wr_addr=0.
- Wrap, WRAP=1: same 17 bytes -> full=0, overflow=0, mem[0]=8'h55, wr_addr=1.
- clear mid-byte: 3 valid bits, then clear=1 for one edge -> bit_cnt=0, wr_addr=0, byte_valid never pulsed; the next 8 bits of 8'hCC land at mem[0].

Source files
------------

// File: rtl/serial_byte_capture_pkg.sv
// Shared constants for the serial byte capture block and its loopback partner.
package serial_byte_capture_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  // Known-good patterns also emitted by the streaming transmitter.
  localparam logic [WIDTH-1:0] PAT_A = 8'hCC;
  localparam logic [WIDTH-1:0] PAT_B = 8'hAA;

endpackage

// File: rtl/serial_byte_capture_bit_assembler.sv
// LSB-first bit assembler: shift register, bit counter and byte completion strobe.
module serial_byte_capture_bit_assembler #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             din,
  input  logic             din_valid,
  output logic [CW-1:0]    bit_cnt,
  output logic             done,
  output logic [WIDTH-1:0] byte_data
);

  localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

  // The top bit never needs storing: it arrives on the completion edge itself.
  logic [WIDTH-2:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q;

  always_comb begin
    shift_d = shift_q;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (cnt_q == CW'(i)) shift_d[i] = din;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (din_valid) begin
      shift_q <= shift_d;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  assign bit_cnt   = cnt_q;
  assign done      = din_valid & ~clear & (cnt_q == LastBit);
  assign byte_data = {din, shift_q};

endmodule

// File: rtl/serial_byte_capture.sv
// Serial-to-parallel receiver writing completed bytes into a small capture memory.
module serial_byte_capture
  import serial_byte_capture_pkg::*;
#(
  parameter int unsigned WIDTH = serial_byte_capture_pkg::WIDTH,
  parameter int unsigned DEPTH = serial_byte_capture_pkg::DEPTH,
  parameter int unsigned AW    = serial_byte_capture_pkg::AW,
  parameter int unsigned WRAP  = 0
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     din,
  input  logic                     din_valid,
  input  logic [AW-1:0]            rd_addr,
  output logic [WIDTH-1:0]         rd_data,
  output logic [WIDTH-1:0]         byte_out,
  output logic                     byte_valid,
  output logic [AW-1:0]            wr_addr,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     full,
  output logic                     overflow
);

  logic             done;
  logic [WIDTH-1:0] byte_data;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_addr_q;
  logic [WIDTH-1:0] byte_out_q;
  logic             byte_valid_q;
  logic             full_q;
  logic             overflow_q;

  serial_byte_capture_bit_assembler #(
    .WIDTH (WIDTH)
  ) u_bit_assembler (
    .clk       (clk),
    .clear     (clear),
    .din       (din),
    .din_valid (din_valid),
    .bit_cnt   (bit_cnt),
    .done      (done),
    .byte_data (byte_data)
  );

  // Capture memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (done && !full_q) mem_q[wr_addr_q] <= byte_data;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_addr_q    <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      full_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      byte_valid_q <= done;
      if (done) begin
        byte_out_q <= byte_data;
        if (!full_q) begin
          wr_addr_q <= wr_addr_q + 1'b1;
          if ((WRAP == 0) && (wr_addr_q == AW'(DEPTH - 1))) full_q <= 1'b1;
        end else begin
          overflow_q <= 1'b1;
        end
      end
    end
  end

  assign rd_data    = mem_q[rd_addr];
  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign wr_addr    = wr_addr_q;
  assign full       = full_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_serial_byte_capture.sv
// Self-checking bench: a stop-at-full and a wrapping instance driven from shared stimulus.
module tb_serial_byte_capture;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic [3:0] rd_addr = 4'd0;

  logic [7:0] rd_data0, byte_out0, rd_data1, byte_out1;
  logic [3:0] wr_addr0, wr_addr1;
  logic [2:0] bit_cnt0, bit_cnt1;
  logic       byte_valid0, full0, overflow0, byte_valid1, full1, overflow1;

  int total = 0;
  int bad = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  always #5 clk = ~clk;

  serial_byte_capture #(.WRAP(0)) dut0 (
    .clk        (clk),
    .clear      (clear),
    .din        (din),
    .din_valid  (din_valid),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data0),
    .byte_out   (byte_out0),
    .byte_valid (byte_valid0),
    .wr_addr    (wr_addr0),
    .bit_cnt    (bit_cnt0),
    .full       (full0),
    .overflow   (overflow0)
  );

  serial_byte_capture #(.WRAP(1)) dut1 (
    .clk        (clk),
    .clear      (clear),
    .din        (din),
    .din_valid  (din_valid),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data1),
    .byte_out   (byte_out1),
    .byte_valid (byte_valid1),
    .wr_addr    (wr_addr1),
    .bit_cnt    (bit_cnt1),
    .full       (full1),
    .overflow   (overflow1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every byte_valid pulse must match the oldest byte sent.
  always @(negedge clk) begin
    if (byte_valid0 === 1'b1) begin
      if (q0.size() == 0) check("dut0 unexpected pulse", {24'd0, byte_out0}, 32'hffff_ffff);
      else check("dut0 byte_out", {24'd0, byte_out0}, {24'd0, q0.pop_front()});
    end
    if (byte_valid1 === 1'b1) begin
      if (q1.size() == 0) check("dut1 unexpected pulse", {24'd0, byte_out1}, 32'hffff_ffff);
      else check("dut1 byte_out", {24'd0, byte_out1}, {24'd0, q1.pop_front()});
    end
  end

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    din = b;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] data, input int gap);
    q0.push_back(data);
    q1.push_back(data);
    for (int i = 0; i < 8; i++) begin
      send_bit(data[i]);
      if (i < 7 && gap > 0) idle(gap);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         gap;
    logic [3:0] wr0;
    logic       full0;
    logic       ovf0;
    logic [3:0] wr1;
  } byte_vec_t;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] exp0;
    logic [7:0] exp1;
  } mem_vec_t;

  byte_vec_t bvec[17];
  mem_vec_t  mvec[16];

  initial begin
    logic [7:0] pat;

    for (int i = 0; i < 16; i++) begin
      bvec[i].data  = (i % 2 == 0) ? 8'hCC : 8'hAA;
      bvec[i].gap   = i % 3;
      bvec[i].wr0   = 4'((i + 1) % 16);
      bvec[i].full0 = (i == 15);
      bvec[i].ovf0  = 1'b0;
      bvec[i].wr1   = 4'((i + 1) % 16);
    end
    bvec[16] = '{data: 8'h55, gap: 1, wr0: 4'd0, full0: 1'b1, ovf0: 1'b1, wr1: 4'd1};
    for (int i = 0; i < 16; i++) begin
      mvec[i].addr = 4'(i);
      mvec[i].exp0 = (i % 2 == 0) ? 8'hCC : 8'hAA;
      mvec[i].exp1 = (i == 0) ? 8'h55 : mvec[i].exp0;
    end

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    do_clear();
    check("reset byte_out", {24'd0, byte_out0}, 32'h0);
    check("reset byte_valid", {31'd0, byte_valid0}, 32'h0);
    check("reset wr_addr", {28'd0, wr_addr0}, 32'h0);
    check("reset bit_cnt", {29'd0, bit_cnt0}, 32'h0);
    check("reset full", {31'd0, full0}, 32'h0);
    check("reset overflow", {31'd0, overflow0}, 32'h0);
    check("reset dut1 wr_addr", {28'd0, wr_addr1}, 32'h0);

    // Single byte on consecutive edges.
    send_byte(8'hCC, 0);
    rd_addr = 4'd0;
    #1;
    check("single byte_valid", {31'd0, byte_valid0}, 32'h1);
    check("single byte_out", {24'd0, byte_out0}, 32'hCC);
    check("single wr_addr", {28'd0, wr_addr0}, 32'h1);
    check("single rd_data", {24'd0, rd_data0}, 32'hCC);
    idle(1);
    check("single pulse width", {31'd0, byte_valid0}, 32'h0);

    // Gapped bits.
    do_clear();
    pat = 8'hAA;
    q0.push_back(pat);
    q1.push_back(pat);
    for (int i = 0; i < 8; i++) begin
      send_bit(pat[i]);
      check("gap bit_cnt", {29'd0, bit_cnt0}, 32'((i + 1) % 8));
      check("gap byte_valid", {31'd0, byte_valid0}, 32'(i == 7));
      if (i < 7) begin
        idle(3);
        check("gap bit_cnt hold", {29'd0, bit_cnt0}, 32'(i + 1));
      end
    end
    check("gap byte_out", {24'd0, byte_out0}, 32'hAA);

    // Fill and overflow / wrap, table driven.
    do_clear();
    for (int i = 0; i < 17; i++) begin
      send_byte(bvec[i].data, bvec[i].gap);
      check("tbl byte_valid", {31'd0, byte_valid0}, 32'h1);
      check("tbl wr_addr0", {28'd0, wr_addr0}, {28'd0, bvec[i].wr0});
      check("tbl full0", {31'd0, full0}, {31'd0, bvec[i].full0});
      check("tbl overflow0", {31'd0, overflow0}, {31'd0, bvec[i].ovf0});
      check("tbl wr_addr1", {28'd0, wr_addr1}, {28'd0, bvec[i].wr1});
      check("tbl full1", {31'd0, full1}, 32'h0);
      check("tbl overflow1", {31'd0, overflow1}, 32'h0);
    end
    check("ovf byte_out", {24'd0, byte_out0}, 32'h55);
    for (int i = 0; i < 16; i++) begin
      rd_addr = mvec[i].addr;
      #1;
      check("mem dut0", {24'd0, rd_data0}, {24'd0, mvec[i].exp0});
      check("mem dut1", {24'd0, rd_data1}, {24'd0, mvec[i].exp1});
    end

    // clear mid-byte discards the partial byte.
    do_clear();
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    check("mid bit_cnt before", {29'd0, bit_cnt0}, 32'h3);
    din_valid = 1'b1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    din_valid = 1'b0;
    check("mid bit_cnt", {29'd0, bit_cnt0}, 32'h0);
    check("mid wr_addr", {28'd0, wr_addr1}, 32'h0);
    check("mid byte_valid", {31'd0, byte_valid1}, 32'h0);
    send_byte(8'hCC, 0);
    rd_addr = 4'd0;
    #1;
    check("mid mem0 dut1", {24'd0, rd_data1}, 32'hCC);
    check("mid wr_addr after", {28'd0, wr_addr0}, 32'h1);

    // clear on the completion edge wins.
    do_clear();
    pat = 8'h55;
    for (int i = 0; i < 7; i++) send_bit(pat[i]);
    din = pat[7];
    din_valid = 1'b1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    din_valid = 1'b0;
    rd_addr = 4'd0;
    #1;
    check("edge byte_valid", {31'd0, byte_valid0}, 32'h0);
    check("edge wr_addr", {28'd0, wr_addr1}, 32'h0);
    check("edge bit_cnt", {29'd0, bit_cnt1}, 32'h0);
    check("edge mem0 dut1", {24'd0, rd_data1}, 32'hCC);
    idle(2);
    check("edge byte_out", {24'd0, byte_out1}, 32'h0);

    check("queue0 drained", 32'(q0.size()), 32'h0);
    check("queue1 drained", 32'(q1.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
